// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for an external up/down counter: lo -> hi -> lo, n times.
// Optional turning-point dwell is built in with `define SWEEP_DWELL_EN.
module counter_sweep_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SWEEP_W      = 4,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]   counter_out,
  output logic               cnt_rst,
  output logic               cnt_enable,
  output logic               cnt_direction,
  output logic               busy,
  output logic               done,
  output logic               err_cfg,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_dwell_range
    $error("DWELL_CYCLES must be in 1..255");
  end

`ifdef SWEEP_DWELL_EN
  typedef enum logic [2:0] {
    IDLE, CLEAR, RAMP, UP, DOWN, DONE, DWELL_HI, DWELL_LO
  } state_t;
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);
  logic [7:0] dcnt;
`else
  typedef enum logic [2:0] {
    IDLE, CLEAR, RAMP, UP, DOWN, DONE
  } state_t;
`endif

  state_t state, state_nx;
  logic [WIDTH-1:0]   lo_r, hi_r;
  logic [SWEEP_W-1:0] n_r;
  logic cfg_ok, accept, at_lo, at_hi, last_sweep;

  assign cfg_ok     = (lo_lim < hi_lim) && (n_sweeps != '0);
  assign accept     = (state == IDLE) && start && cfg_ok;
  assign at_lo      = (counter_out == lo_r);
  assign at_hi      = (counter_out == hi_r);
  assign last_sweep = ((sweep_cnt + SWEEP_W'(1)) == n_r);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_r      <= '0;
      hi_r      <= '0;
      n_r       <= '0;
      sweep_cnt <= '0;
      err_cfg   <= 1'b0;
    end else begin
      err_cfg <= (state == IDLE) && start && !cfg_ok;
      if (accept) begin
        lo_r      <= lo_lim;
        hi_r      <= hi_lim;
        n_r       <= n_sweeps;
        sweep_cnt <= '0;
      end else if (state == DOWN && at_lo && !stop) begin
        sweep_cnt <= sweep_cnt + SWEEP_W'(1);
      end
    end
  end

`ifdef SWEEP_DWELL_EN
  // Loaded on the turning cycle itself, so that cycle counts as the first held one.
  always_ff @(posedge clk) begin
    if (rst)
      dcnt <= '0;
    else if ((state == UP && at_hi) || (state == DOWN && at_lo && !last_sweep))
      dcnt <= DWELL_LOAD;
    else if (dcnt != '0)
      dcnt <= dcnt - 8'd1;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = CLEAR;
      CLEAR: state_nx = RAMP;
      RAMP:  if (at_lo) state_nx = UP;
`ifdef SWEEP_DWELL_EN
      UP:    if (at_hi) state_nx = DWELL_HI;
      DOWN:  if (at_lo) state_nx = last_sweep ? DONE : DWELL_LO;
      DWELL_HI: if (dcnt == '0) state_nx = DOWN;
      DWELL_LO: if (dcnt == '0) state_nx = UP;
`else
      UP:    if (at_hi) state_nx = DOWN;
      DOWN:  if (at_lo) state_nx = last_sweep ? DONE : UP;
`endif
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (stop && state != IDLE) state_nx = IDLE;
  end

  always_comb begin
    cnt_enable    = 1'b0;
    cnt_direction = 1'b1;
    case (state)
      RAMP: cnt_enable = 1'b1;
      UP: begin
        cnt_enable = 1'b1;
        if (at_hi) begin
          cnt_direction = 1'b0;
`ifdef SWEEP_DWELL_EN
          cnt_enable = 1'b0;
`endif
        end
      end
      DOWN: begin
        cnt_enable    = 1'b1;
        cnt_direction = 1'b0;
        if (at_lo) begin
          cnt_direction = 1'b1;
`ifdef SWEEP_DWELL_EN
          cnt_enable = 1'b0;
`else
          cnt_enable = !last_sweep;
`endif
        end
      end
`ifdef SWEEP_DWELL_EN
      DWELL_HI: begin
        cnt_enable    = (dcnt == '0);
        cnt_direction = 1'b0;
      end
      DWELL_LO: cnt_enable = (dcnt == '0);
`endif
      default: cnt_enable = 1'b0;
    endcase
    if (stop || rst) cnt_enable = 1'b0;
  end

  assign cnt_rst = rst || (state == CLEAR);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench: emulates the counter, predicts each cycle from a sweep-sequence model.
module tb_counter_sweep_ctrl;
`ifdef SWEEP_DWELL_EN
  localparam int unsigned DW    = 3;
  localparam bit          DWELL = 1'b1;
`else
  localparam int unsigned DW    = 4;
  localparam bit          DWELL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] lo_lim, hi_lim, counter_out;
  logic [3:0] n_sweeps, sweep_cnt;
  logic       cnt_rst, cnt_enable, cnt_direction, busy, done, err_cfg;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .n_sweeps(n_sweeps),
    .counter_out(counter_out), .cnt_rst(cnt_rst), .cnt_enable(cnt_enable),
    .cnt_direction(cnt_direction), .busy(busy), .done(done),
    .err_cfg(err_cfg), .sweep_cnt(sweep_cnt)
  );

  // The 8-bit up/down counter this block drives.
  always @(posedge clk) begin
    if (cnt_rst)         counter_out <= '0;
    else if (cnt_enable) counter_out <= cnt_direction ? counter_out + 8'd1 : counter_out - 8'd1;
  end

  typedef struct {
    int cnt; bit en; bit dir; bit dn; int sw; bit clr;
  } rec_t;

  rec_t q[$];
  int   idle_cnt = -1;
  int   idle_sw  = 0;
  bit   err_pend = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   trace[$];
  bit   tracing = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Expected per-cycle view of an accepted run, starting with the clear cycle.
  function automatic void build(int lo, int hi, int n);
    int v[$];
    int s[$];
    rec_t r;
    for (int x = 0; x <= lo; x++) begin v.push_back(x); s.push_back(0); end
    for (int k = 1; k <= n; k++) begin
      for (int x = lo + 1; x <= hi; x++) begin v.push_back(x); s.push_back(k - 1); end
      if (DWELL) repeat (DW) begin v.push_back(hi); s.push_back(k - 1); end
      for (int x = hi - 1; x >= lo; x--) begin v.push_back(x); s.push_back(k - 1); end
      if (DWELL && k < n) repeat (DW) begin v.push_back(lo); s.push_back(k); end
    end
    v.push_back(lo); s.push_back(n);
    q.delete();
    r = '{cnt: 0, en: 1'b0, dir: 1'b1, dn: 1'b0, sw: 0, clr: 1'b1};
    q.push_back(r);
    for (int i = 0; i < v.size(); i++) begin
      r.clr = 1'b0; r.cnt = v[i]; r.sw = s[i];
      r.dn  = (i == v.size() - 1);
      r.en  = 1'b0; r.dir = 1'b1;
      if (!r.dn) begin
        r.en  = (v[i+1] != v[i]);
        r.dir = r.en ? (v[i+1] > v[i]) : 1'b1;
      end
      q.push_back(r);
    end
  endfunction

  task automatic step(bit r, bit st, bit sp, int lo, int hi, int n);
    rec_t rec;
    bit   act, e_en;
    @(negedge clk);
    rst = r; start = st; stop = sp;
    lo_lim = 8'(lo); hi_lim = 8'(hi); n_sweeps = 4'(n);
    #1;
    act = (q.size() > 0);
    if (act) rec = q[0];
    e_en = act && !r && !sp && rec.en;
    chk("busy", busy, act);
    chk("done", done, act ? rec.dn : 1'b0);
    chk("err_cfg", err_cfg, err_pend);
    chk("sweep_cnt", sweep_cnt, act ? rec.sw : idle_sw);
    chk("cnt_rst", cnt_rst, r || (act && rec.clr));
    chk("cnt_enable", cnt_enable, e_en);
    if (e_en) chk("cnt_direction", cnt_direction, rec.dir);
    if (!act) chk("idle_direction", cnt_direction, 1);
    if (act && !rec.clr) chk("counter_out", counter_out, rec.cnt);
    else if (!act && idle_cnt >= 0) chk("counter_hold", counter_out, idle_cnt);
    if (act && !rec.clr && tracing) trace.push_back(int'(counter_out));
    if (r) begin
      q.delete(); idle_cnt = 0; idle_sw = 0; err_pend = 1'b0;
    end else if (act) begin
      err_pend = 1'b0;
      if (sp) begin
        idle_cnt = rec.clr ? 0 : rec.cnt; idle_sw = rec.sw; q.delete();
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) begin idle_cnt = rec.cnt; idle_sw = rec.sw; end
      end
    end else begin
      err_pend = st && (lo >= hi || n == 0);
      if (st && !err_pend) build(lo, hi, n);
    end
  endtask

  task automatic idle_step();
    step(1'b0, ($urandom_range(0, 3) == 0), 1'b0, $urandom_range(0, 9), $urandom_range(0, 9), 1);
  endtask

  task automatic run_until_idle();
    int guard = 0;
    while (q.size() > 0 && guard < 2000) begin idle_step(); guard++; end
    if (guard >= 2000) chk("run_timeout", guard, 0);
  endtask

  task automatic run_traced(int lo, int hi, int n);
    trace.delete(); tracing = 1'b1;
    step(1'b0, 1'b1, 1'b0, lo, hi, n);
    run_until_idle();
    tracing = 1'b0;
  endtask

  task automatic stop_or_rst_at(int lo, int hi, int v, bit up, bit use_rst);
    int guard = 0;
    step(1'b0, 1'b1, 1'b0, lo, hi, 1);
    while (!(q.size() > 0 && !q[0].clr && q[0].cnt == v && q[0].en && q[0].dir == up) && guard < 100) begin
      idle_step(); guard++;
    end
    if (guard >= 100) chk("seek_timeout", guard, 0);
    step(use_rst, 1'b0, !use_rst, 0, 0, 0);
  endtask

  initial begin
    int bad_r, lo, hi, n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; lo_lim = '0; hi_lim = '0; n_sweeps = '0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sweep_cnt", sweep_cnt, 0);
    chk("reset_counter", counter_out, 0);

`ifndef SWEEP_DWELL_EN
    begin
      int e1[10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 2};
      int e2[16] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2, 2};
      run_traced(2, 5, 1);
      chk("t1_len", trace.size(), 10);
      foreach (e1[i]) if (i < trace.size()) chk("t1_seq", trace[i], e1[i]);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      chk("t1_sweep_cnt", sweep_cnt, 1);
      chk("t1_hold", counter_out, 2);
      run_traced(2, 5, 2);
      chk("t2_len", trace.size(), 16);
      foreach (e2[i]) if (i < trace.size()) chk("t2_seq", trace[i], e2[i]);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      chk("t2_sweep_cnt", sweep_cnt, 2);
    end
`else
    begin
      int e6[19] = '{0, 1, 2, 2, 2, 2, 1, 0, 0, 0, 0, 1, 2, 2, 2, 2, 1, 0, 0};
      run_traced(0, 2, 2);
      chk("t6_len", trace.size(), 19);
      foreach (e6[i]) if (i < trace.size()) chk("t6_seq", trace[i], e6[i]);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      chk("t6_sweep_cnt", sweep_cnt, 2);
    end
`endif

    step(1'b0, 1'b1, 1'b0, 5, 5, 1);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("t3_err_lo_eq_hi", err_cfg, 1);
    step(1'b0, 1'b1, 1'b1, 2, 5, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("t3_err_n0", err_cfg, 1);
    chk("t3_busy", busy, 0);

    stop_or_rst_at(2, 5, 4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("t4_stop_hold", counter_out, 4);
    chk("t4_stop_busy", busy, 0);
    run_traced(1, 3, 1);

    stop_or_rst_at(2, 5, 3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("t5_rst_counter", counter_out, 0);
    chk("t5_rst_busy", busy, 0);

    run_traced(254, 255, 2);
    run_traced(0, 1, 3);

    for (int c = 0; c < 4000; c++) begin
      bad_r = $urandom_range(0, 9);
      lo = $urandom_range(0, 30);
      hi = lo + $urandom_range(1, 25);
      if (bad_r == 0) hi = $urandom_range(0, lo);
      if (bad_r == 1) begin lo = $urandom_range(240, 254); hi = 255; end
      n = $urandom_range(0, 3);
      step(($urandom_range(0, 699) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 149) == 0), lo, hi, n);
    end
    run_until_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
